// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage for the 8-bit core. Reads a byte-wide synchronous instruction
//   memory, assembles 1-byte ops and 2-byte load-immediate (op + imm) pairs,
//   and queues them for the execute stage.
// Ports
//   clk, rst                   clock / synchronous active-high reset
//   imem_en, imem_addr         memory read strobe and address
//   imem_rdata                 read data, valid the cycle after imem_en
//   redirect_valid/_pc         flush and restart fetch at redirect_pc
//   out_valid/out_ready        head-of-queue handshake
//   out_instr/out_imm/out_pc   head entry (imm is 0 for non-LI ops)
//   halted                     HALT enqueued, fetching stopped
module instr_fetch_unit #(
  parameter int                ADDR_W      = 8,
  parameter int                DEPTH       = 2,
  parameter logic [2:0]        LI_OPCODE   = 3'b010,
  parameter logic [2:0]        HALT_OPCODE = 3'b111,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_instr,
  output logic [7:0]        out_imm,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_OP, WAIT_IMM} state_t;

  typedef struct packed {
    logic [7:0]        instr;
    logic [7:0]        imm;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] op_pc;     // address of the op byte currently in flight
  logic [7:0]        li_op;     // LI op byte held while its immediate is fetched
  entry_t            q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count, count_nxt;

  logic       push, pop, space, issue_op, issue_imm;
  entry_t     push_e;
  logic [CNT_W:0] cnt_after;
  logic [2:0] op;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign op = imem_rdata[7:5];

  always_comb begin
    push      = 1'b0;
    push_e    = '0;
    issue_op  = 1'b0;
    issue_imm = 1'b0;
    case (state)
      WAIT_OP: begin
        if (op == LI_OPCODE) issue_imm = 1'b1;
        else begin
          push   = 1'b1;
          push_e = '{instr: imem_rdata, imm: 8'h00, pc: op_pc};
        end
      end
      WAIT_IMM: begin
        push   = 1'b1;
        push_e = '{instr: li_op, imm: imem_rdata, pc: op_pc};
      end
      default: ;
    endcase
    // A same-cycle pop is deliberately not credited: the space check only
    // looks at registered occupancy plus this cycle's push.
    cnt_after = {1'b0, count} + {{CNT_W{1'b0}}, push};
    space     = cnt_after < DEPTH_C;
    case (state)
      IDLE:     issue_op = space && !halted;
      WAIT_OP:  issue_op = space && (op != LI_OPCODE) && (op != HALT_OPCODE);
      WAIT_IMM: issue_op = space;
      default:  issue_op = 1'b0;
    endcase
  end

  assign imem_en   = (issue_op | issue_imm) & ~redirect_valid & ~rst;
  assign imem_addr = fetch_pc;
  assign pop       = out_valid & out_ready;

  always_comb begin
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  assign out_instr = q[rd_ptr].instr;
  assign out_imm   = q[rd_ptr].imm;
  assign out_pc    = q[rd_ptr].pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      op_pc     <= '0;
      li_op     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else if (redirect_valid) begin
      // Any handshake this cycle is consumed by emptying the queue; the byte
      // returning next cycle is ignored because the FSM is back in IDLE.
      state     <= IDLE;
      fetch_pc  <= redirect_pc;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
    end else begin
      if (imem_en)  fetch_pc <= fetch_pc + 1'b1;
      if (issue_op) op_pc    <= fetch_pc;
      case (state)
        IDLE: if (issue_op) state <= WAIT_OP;
        WAIT_OP: begin
          if (op == LI_OPCODE) begin
            li_op <= imem_rdata;
            state <= WAIT_IMM;
          end else if (op == HALT_OPCODE) begin
            halted <= 1'b1;
            state  <= IDLE;
          end else begin
            state <= issue_op ? WAIT_OP : IDLE;
          end
        end
        WAIT_IMM: state <= issue_op ? WAIT_OP : IDLE;
        default:  state <= IDLE;
      endcase
      if (push) begin
        q[wr_ptr] <= push_e;
        wr_ptr    <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count     <= count_nxt;
      out_valid <= (count_nxt != '0);
    end
  end

  // Issue gating must keep every push within capacity.
  assert property (@(posedge clk) disable iff (rst || redirect_valid)
                   !(push && count == CNT_W'(DEPTH)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
//   Directed checks of instr_fetch_unit (default parameters, DEPTH=2) against
//   a byte-wide synchronous memory model. Inputs change just after the falling
//   edge; outputs are sampled 1ns later. Cycle c1 is the first cycle with rst
//   low. With DEPTH=2 and no pop credit, a stream of 1-byte ops shows a bubble
//   every third cycle.
module tb_instr_fetch_unit;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       imem_en;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       redirect_valid = 1'b0;
  logic [7:0] redirect_pc = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_instr, out_imm, out_pc;
  logic       halted;

  logic [7:0] mem [256];
  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_imm(out_imm), .out_pc(out_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [7:0] i, input logic [7:0] m,
                          input logic [7:0] p);
    chk({tag, "_vld"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_ins"}, {24'b0, out_instr}, {24'b0, i});
    chk({tag, "_imm"}, {24'b0, out_imm}, {24'b0, m});
    chk({tag, "_pc"},  {24'b0, out_pc}, {24'b0, p});
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h01;
  endtask

  // Hold reset two edges and check the reset outputs; rst left high.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    redirect_valid = 1'b0;
    repeat (2) step();
    chk({tag, "_rst_en"},  {31'b0, imem_en}, 32'd0);
    chk({tag, "_rst_vld"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_rst_hlt"}, {31'b0, halted}, 32'd0);
    chk({tag, "_rst_ins"}, {24'b0, out_instr}, 32'd0);
    chk({tag, "_rst_imm"}, {24'b0, out_imm}, 32'd0);
    chk({tag, "_rst_pc"},  {24'b0, out_pc}, 32'd0);
  endtask

  task automatic release_c1();
    step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int k;

    // ---- 1: stream of 1-byte ops
    fill_mem();
    mem[0] = 8'h0D; mem[1] = 8'h2D; mem[2] = 8'h6B;
    out_ready = 1'b1;
    do_reset("t1");
    release_c1();
    chk("t1_c1_en", {31'b0, imem_en}, 32'd1);
    chk("t1_c1_addr", {24'b0, imem_addr}, 32'h00);
    chk("t1_c1_vld", {31'b0, out_valid}, 32'd0);
    step();
    chk("t1_c2_vld", {31'b0, out_valid}, 32'd0);
    chk("t1_c2_addr", {24'b0, imem_addr}, 32'h01);
    step(); chk_head("t1_c3", 8'h0D, 8'h00, 8'h00);
    step(); chk_head("t1_c4", 8'h2D, 8'h00, 8'h01);
    step(); chk("t1_c5_vld", {31'b0, out_valid}, 32'd0);
    step(); chk_head("t1_c6", 8'h6B, 8'h00, 8'h02);

    // ---- 2: load-immediate pair then 1-byte op
    fill_mem();
    mem[0] = 8'h40; mem[1] = 8'h05; mem[2] = 8'h0D;
    do_reset("t2");
    release_c1();
    chk("t2_c1_addr", {24'b0, imem_addr}, 32'h00);
    chk("t2_c1_en", {31'b0, imem_en}, 32'd1);
    step();
    chk("t2_c2_addr", {24'b0, imem_addr}, 32'h01);
    chk("t2_c2_en", {31'b0, imem_en}, 32'd1);
    step();
    chk("t2_c3_addr", {24'b0, imem_addr}, 32'h02);
    chk("t2_c3_en", {31'b0, imem_en}, 32'd1);
    chk("t2_c3_vld", {31'b0, out_valid}, 32'd0);
    step(); chk_head("t2_c4", 8'h40, 8'h05, 8'h00);
    step(); chk_head("t2_c5", 8'h0D, 8'h00, 8'h02);

    // ---- 3: backpressure fills exactly DEPTH entries, then drains in order
    fill_mem();
    for (int i = 0; i < 8; i++) mem[i] = 8'(i + 1);
    out_ready = 1'b0;
    do_reset("t3");
    release_c1();
    repeat (5) step();
    chk("t3_c6_en", {31'b0, imem_en}, 32'd0);
    chk("t3_c6_addr", {24'b0, imem_addr}, 32'h02);
    chk_head("t3_c6", 8'h01, 8'h00, 8'h00);
    repeat (2) step();
    chk("t3_c8_en", {31'b0, imem_en}, 32'd0);
    chk("t3_c8_addr", {24'b0, imem_addr}, 32'h02);
    out_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 20 && k < 4; i++) begin
      if (out_valid) begin
        chk("t3_drain_pc", {24'b0, out_pc}, k);
        chk("t3_drain_ins", {24'b0, out_instr}, k + 1);
        k++;
      end
      step();
    end
    chk("t3_drain_n", k, 32'd4);

    // ---- 4: redirect while the immediate byte is in flight
    fill_mem();
    mem[0] = 8'h40; mem[1] = 8'h55; mem[8'h80] = 8'h11;
    out_ready = 1'b1;
    do_reset("t4");
    release_c1();
    repeat (2) step();                     // c3: WAIT_IMM
    redirect_valid = 1'b1; redirect_pc = 8'h80;
    #1;
    chk("t4_c3_en", {31'b0, imem_en}, 32'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t4_c4_vld", {31'b0, out_valid}, 32'd0);
    chk("t4_c4_en", {31'b0, imem_en}, 32'd1);
    chk("t4_c4_addr", {24'b0, imem_addr}, 32'h80);
    step(); chk("t4_c5_vld", {31'b0, out_valid}, 32'd0);
    step(); chk_head("t4_c6", 8'h11, 8'h00, 8'h80);

    // ---- 5: HALT stops fetch; redirect clears it
    fill_mem();
    mem[3] = 8'hE0;
    mem[8'hFF] = 8'h48;
    do_reset("t5");
    release_c1();
    for (int i = 0; i < 20 && halted !== 1'b1; i++) step();
    chk("t5_halted", {31'b0, halted}, 32'd1);
    chk_head("t5_halt", 8'hE0, 8'h00, 8'h03);
    chk("t5_halt_en", {31'b0, imem_en}, 32'd0);
    repeat (3) step();
    chk("t5_stop_en", {31'b0, imem_en}, 32'd0);
    chk("t5_stop_hlt", {31'b0, halted}, 32'd1);
    chk("t5_stop_addr", {24'b0, imem_addr}, 32'h04);
    redirect_valid = 1'b1; redirect_pc = 8'h00;
    #1;
    chk("t5_rd_en", {31'b0, imem_en}, 32'd0);
    step();
    redirect_valid = 1'b0;
    mem[0] = 8'h22;
    #1;
    chk("t5_res_hlt", {31'b0, halted}, 32'd0);
    chk("t5_res_en", {31'b0, imem_en}, 32'd1);
    chk("t5_res_addr", {24'b0, imem_addr}, 32'h00);

    // ---- 6: LI at the top address wraps its immediate fetch to 0
    step();
    redirect_valid = 1'b1; redirect_pc = 8'hFF;
    #1;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t6_r1_addr", {24'b0, imem_addr}, 32'hFF);
    chk("t6_r1_en", {31'b0, imem_en}, 32'd1);
    step(); chk("t6_r2_addr", {24'b0, imem_addr}, 32'h00);
    step();
    chk("t6_r3_addr", {24'b0, imem_addr}, 32'h01);
    chk("t6_r3_en", {31'b0, imem_en}, 32'd1);
    step(); chk_head("t6_r4", 8'h48, 8'h22, 8'hFF);
    out_ready = 1'b0;
    repeat (3) step();
    chk("t6_pre_vld", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_en0", {31'b0, imem_en}, 32'd0);
    step();
    chk("t6_rst_vld", {31'b0, out_valid}, 32'd0);
    chk("t6_rst_ins", {24'b0, out_instr}, 32'd0);
    chk("t6_rst_imm", {24'b0, out_imm}, 32'd0);
    chk("t6_rst_pc",  {24'b0, out_pc}, 32'd0);
    chk("t6_rst_hlt", {31'b0, halted}, 32'd0);
    chk("t6_rst_en",  {31'b0, imem_en}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("t6_post_addr", {24'b0, imem_addr}, 32'h00);
    chk("t6_post_en", {31'b0, imem_en}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
